// File: rtl/mcmc_assignment_manager.sv
// Purpose : holds the MCMC solver's current assignment, commits proposals, captures the first solution or flags timeout.
// Latency : start -> CHECK 1 cycle; handshake -> updated out_current_* 1 cycle; minimum 2 cycles per iteration.
// Backpr. : out_proposal_ready is high only in ISSUE; the engine waits there indefinitely until in_proposal_valid.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_start + in_initial_*  start pulse, budget and initial assignment (sampled only in IDLE/DONE)
//   out_current_*            registered current assignment, feeds the constraint checker
//   in_current_satisfied     checker verdict on out_current_*, sampled in CHECK
//   in_proposal_* / out_proposal_ready   proposal handshake from the search engine
//   out_*_valid_solution, out_solution_valid, out_timeout, out_busy, out_iteration_count   status
//
// Optional: define MCMC_RANDOM_RESTART_EN to add RESTART_PERIOD; every RESTART_PERIOD-th
// handshake reloads the assignment latched at start instead of the proposal.
module mcmc_assignment_manager #(
    parameter int NUM_BOOL = 8,
    parameter int NUM_INT  = 4,
    parameter int INT_W    = 8,
    parameter int ITER_W   = 16
`ifdef MCMC_RANDOM_RESTART_EN
    ,
    parameter int RESTART_PERIOD = 64
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_start,
    input  logic [ITER_W-1:0]          in_max_iterations,
    input  logic [NUM_BOOL-1:0]        in_initial_boolean,
    input  logic [NUM_INT*INT_W-1:0]   in_initial_integer,
    output logic [NUM_BOOL-1:0]        out_current_boolean,
    output logic [NUM_INT*INT_W-1:0]   out_current_integer,
    output logic                       out_proposal_ready,
    input  logic                       in_proposal_valid,
    input  logic                       in_proposal_accept,
    input  logic [NUM_BOOL-1:0]        in_proposal_boolean,
    input  logic [NUM_INT*INT_W-1:0]   in_proposal_integer,
    input  logic                       in_current_satisfied,
    output logic [NUM_BOOL-1:0]        out_boolean_valid_solution,
    output logic [NUM_INT*INT_W-1:0]   out_integer_valid_solution,
    output logic                       out_solution_valid,
    output logic                       out_timeout,
    output logic                       out_busy,
    output logic [ITER_W-1:0]          out_iteration_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ITER_W-1:0] budget;

`ifdef MCMC_RANDOM_RESTART_EN
    localparam int RC_W = $clog2(RESTART_PERIOD + 1);

    logic [NUM_BOOL-1:0]      init_boolean;
    logic [NUM_INT*INT_W-1:0] init_integer;
    logic [RC_W-1:0]          restart_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= S_IDLE;
            budget                     <= '0;
            out_current_boolean        <= '0;
            out_current_integer        <= '0;
            out_proposal_ready         <= 1'b0;
            out_boolean_valid_solution <= '0;
            out_integer_valid_solution <= '0;
            out_solution_valid         <= 1'b0;
            out_timeout                <= 1'b0;
            out_busy                   <= 1'b0;
            out_iteration_count        <= '0;
`ifdef MCMC_RANDOM_RESTART_EN
            init_boolean               <= '0;
            init_integer               <= '0;
            restart_cnt                <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Solution registers are deliberately not cleared here: they
                    // keep the last captured solution until a new one is found.
                    if (in_start) begin
                        out_current_boolean <= in_initial_boolean;
                        out_current_integer <= in_initial_integer;
                        budget              <= in_max_iterations;
                        out_iteration_count <= '0;
                        out_solution_valid  <= 1'b0;
                        out_timeout         <= 1'b0;
                        out_busy            <= 1'b1;
`ifdef MCMC_RANDOM_RESTART_EN
                        init_boolean        <= in_initial_boolean;
                        init_integer        <= in_initial_integer;
                        restart_cnt         <= '0;
`endif
                        state               <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    // A satisfied assignment beats an exhausted budget.
                    if (in_current_satisfied) begin
                        out_boolean_valid_solution <= out_current_boolean;
                        out_integer_valid_solution <= out_current_integer;
                        out_solution_valid         <= 1'b1;
                        out_busy                   <= 1'b0;
                        state                      <= S_DONE;
                    end else if (out_iteration_count == budget) begin
                        out_timeout <= 1'b1;
                        out_busy    <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        out_proposal_ready <= 1'b1;
                        state              <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (in_proposal_valid) begin
                        out_iteration_count <= out_iteration_count + ITER_W'(1);
                        out_proposal_ready  <= 1'b0;
                        state               <= S_CHECK;
`ifdef MCMC_RANDOM_RESTART_EN
                        // The handshake that completes a period restarts from
                        // the start assignment regardless of the accept bit.
                        if (restart_cnt == RC_W'(RESTART_PERIOD - 1)) begin
                            out_current_boolean <= init_boolean;
                            out_current_integer <= init_integer;
                            restart_cnt         <= '0;
                        end else begin
                            restart_cnt <= restart_cnt + RC_W'(1);
                            if (in_proposal_accept) begin
                                out_current_boolean <= in_proposal_boolean;
                                out_current_integer <= in_proposal_integer;
                            end
                        end
`else
                        if (in_proposal_accept) begin
                            out_current_boolean <= in_proposal_boolean;
                            out_current_integer <= in_proposal_integer;
                        end
`endif
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcmc_assignment_manager.sv
// Purpose : self-checking bench for mcmc_assignment_manager against a sequential reference model.
// Latency : checks start->CHECK->DONE timing and per-handshake assignment updates.
// Backpr. : drives proposals only while out_proposal_ready, with random gaps and ignored noise elsewhere.
module tb_mcmc_assignment_manager;

    localparam int NB  = 8;
    localparam int NI  = 4;
    localparam int IW  = 8;
    localparam int ITW = 16;
    localparam int IWT = NI * IW;
    localparam int RP  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_start = 1'b0;
    logic [ITW-1:0]   in_max_iterations = '0;
    logic [NB-1:0]    in_initial_boolean = '0;
    logic [IWT-1:0]   in_initial_integer = '0;
    logic [NB-1:0]    out_current_boolean;
    logic [IWT-1:0]   out_current_integer;
    logic             out_proposal_ready;
    logic             in_proposal_valid = 1'b0;
    logic             in_proposal_accept = 1'b0;
    logic [NB-1:0]    in_proposal_boolean = '0;
    logic [IWT-1:0]   in_proposal_integer = '0;
    logic             in_current_satisfied;
    logic [NB-1:0]    out_boolean_valid_solution;
    logic [IWT-1:0]   out_integer_valid_solution;
    logic             out_solution_valid;
    logic             out_timeout;
    logic             out_busy;
    logic [ITW-1:0]   out_iteration_count;

    // Constraint checker stand-in: satisfied when the Boolean part hits a target.
    logic             sat_en = 1'b0;
    logic [NB-1:0]    sat_target = '0;
    assign in_current_satisfied = sat_en && (out_current_boolean == sat_target);

    int checks = 0;
    int errors = 0;

    // Proposal stream, observed per-handshake trace and model expectations.
    logic [NB-1:0]  prop_b [64];
    logic [IWT-1:0] prop_i [64];
    logic           prop_a [64];
    logic [NB-1:0]  obs_b  [64];
    logic [IWT-1:0] obs_i  [64];
    logic [NB-1:0]  exp_b  [64];
    logic [IWT-1:0] exp_i  [64];
    logic           exp_sv, exp_to;
    int             exp_cnt;
    logic [NB-1:0]  exp_cur_b, m_sol_b;
    logic [IWT-1:0] exp_cur_i, m_sol_i;

    mcmc_assignment_manager #(
        .NUM_BOOL (NB),
        .NUM_INT  (NI),
        .INT_W    (IW),
        .ITER_W   (ITW)
`ifdef MCMC_RANDOM_RESTART_EN
        ,
        .RESTART_PERIOD (RP)
`endif
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .in_start                   (in_start),
        .in_max_iterations          (in_max_iterations),
        .in_initial_boolean         (in_initial_boolean),
        .in_initial_integer         (in_initial_integer),
        .out_current_boolean        (out_current_boolean),
        .out_current_integer        (out_current_integer),
        .out_proposal_ready         (out_proposal_ready),
        .in_proposal_valid          (in_proposal_valid),
        .in_proposal_accept         (in_proposal_accept),
        .in_proposal_boolean        (in_proposal_boolean),
        .in_proposal_integer        (in_proposal_integer),
        .in_current_satisfied       (in_current_satisfied),
        .out_boolean_valid_solution (out_boolean_valid_solution),
        .out_integer_valid_solution (out_integer_valid_solution),
        .out_solution_valid         (out_solution_valid),
        .out_timeout                (out_timeout),
        .out_busy                   (out_busy),
        .out_iteration_count        (out_iteration_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: walk the solver loop as the algorithm reads -- check, stop on
    // solution or exhausted budget, else consume the next proposal.
    task automatic model_run(input logic [NB-1:0] b, input logic [IWT-1:0] iv, input int bud);
        logic [NB-1:0]  cb;
        logic [IWT-1:0] ci;
`ifdef MCMC_RANDOM_RESTART_EN
        int rc;
        rc = 0;
`endif
        cb = b; ci = iv;
        exp_sv = 1'b0; exp_to = 1'b0; exp_cnt = 0;
        for (int k = 0; k <= bud; k++) begin
            if (sat_en && cb == sat_target) begin
                exp_sv = 1'b1; m_sol_b = cb; m_sol_i = ci;
                break;
            end
            if (exp_cnt == bud) begin
                exp_to = 1'b1;
                break;
            end
            exp_cnt++;
`ifdef MCMC_RANDOM_RESTART_EN
            rc++;
            if (rc == RP) begin
                cb = b; ci = iv; rc = 0;
            end else if (prop_a[k]) begin
                cb = prop_b[k]; ci = prop_i[k];
            end
`else
            if (prop_a[k]) begin
                cb = prop_b[k]; ci = prop_i[k];
            end
`endif
            exp_b[k] = cb; exp_i[k] = ci;
        end
        exp_cur_b = cb; exp_cur_i = ci;
    endtask

    task automatic start_run(input logic [NB-1:0] b, input logic [IWT-1:0] iv, input int bud);
        @(negedge clk);
        in_start = 1'b1;
        in_initial_boolean = b;
        in_initial_integer = iv;
        in_max_iterations = ITW'(bud);
        @(negedge clk);
        in_start = 1'b0;
    endtask

    // Feeds prop_* in order while the DUT is ready; records the assignment seen
    // one cycle after each handshake. With noise, adds gaps and junk that the
    // DUT must ignore (proposals outside ISSUE, start while busy).
    task automatic drive_run(input int max_cyc, input bit noise,
                             output bit done_ok, output int hs, output bit ready_seen);
        bit pend;
        pend = 1'b0; done_ok = 1'b0; hs = 0; ready_seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (pend) begin
                obs_b[hs-1] = out_current_boolean;
                obs_i[hs-1] = out_current_integer;
                pend = 1'b0;
            end
            in_start = 1'b0;
            in_proposal_valid = 1'b0;
            if (out_proposal_ready) begin
                ready_seen = 1'b1;
                if (!noise || $urandom_range(0, 2) != 0) begin
                    in_proposal_valid   = 1'b1;
                    in_proposal_boolean = (hs < 64) ? prop_b[hs] : '0;
                    in_proposal_integer = (hs < 64) ? prop_i[hs] : '0;
                    in_proposal_accept  = (hs < 64) ? prop_a[hs] : 1'b0;
                    hs++;
                    pend = 1'b1;
                end
            end else if (!out_busy && (out_solution_valid || out_timeout)) begin
                done_ok = 1'b1;
                break;
            end else if (noise) begin
                in_proposal_valid   = 1'($urandom_range(0, 1));
                in_proposal_accept  = 1'($urandom_range(0, 1));
                in_proposal_boolean = NB'($urandom);
                in_proposal_integer = IWT'($urandom);
                in_start            = out_busy && ($urandom_range(0, 3) == 0);
                in_initial_boolean  = NB'($urandom);
                in_initial_integer  = IWT'($urandom);
                in_max_iterations   = ITW'($urandom);
            end
        end
        in_proposal_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic test_reset;
        bit got_ready;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_current_boolean, out_current_integer, out_proposal_ready, out_solution_valid,
             out_timeout, out_busy, out_iteration_count,
             out_boolean_valid_solution, out_integer_valid_solution} !== '0) begin
            errors++;
            $display("FAIL reset_state outputs not all zero: cur=%h/%h busy=%b cnt=%0d", out_current_boolean,
                     out_current_integer, out_busy, out_iteration_count);
        end
        rst = 1'b0;
        sat_en = 1'b0;
        start_run(8'h3C, 32'h11223344, 10);
        got_ready = 1'b0;
        for (int c = 0; c < 10 && !got_ready; c++) begin
            @(negedge clk);
            got_ready = out_proposal_ready;
        end
        checks++;
        if (got_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_issue ready=%b want 1", got_ready);
        end
        // Proposal in flight while reset is asserted must be dropped.
        in_proposal_valid = 1'b1; in_proposal_accept = 1'b1;
        in_proposal_boolean = 8'hFF; in_proposal_integer = 32'hFFFF_FFFF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_proposal_ready !== 1'b0 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_issue_ctrl ready=%b busy=%b want 0 0", out_proposal_ready, out_busy);
        end
        checks++;
        if (out_current_boolean !== '0 || out_current_integer !== '0 || out_iteration_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_issue_data cur=%h/%h cnt=%0d want 0", out_current_boolean,
                     out_current_integer, out_iteration_count);
        end
        checks++;
        if (out_solution_valid !== 1'b0 || out_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_issue_flags sv=%b to=%b want 0 0", out_solution_valid, out_timeout);
        end
        in_proposal_valid = 1'b0;
        rst = 1'b0;
        m_sol_b = '0; m_sol_i = '0;
    endtask

    task automatic test_timeout;
        bit ok, rs; int hs;
        sat_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            prop_b[k] = NB'(k + 1); prop_i[k] = IWT'($urandom); prop_a[k] = 1'b1;
        end
        start_run(8'h00, 32'h0, 3);
        drive_run(100, 1'b0, ok, hs, rs);
        checks++;
        if (!ok || out_timeout !== 1'b1 || out_solution_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags done=%b to=%b sv=%b want 1 1 0", ok, out_timeout, out_solution_valid);
        end
        checks++;
        if (out_current_boolean !== 8'h03 || out_iteration_count !== 16'd3) begin
            errors++;
            $display("FAIL timeout_state cur=%h cnt=%0d want 03 3", out_current_boolean, out_iteration_count);
        end
`ifndef MCMC_RANDOM_RESTART_EN
        checks++;
        if (out_current_integer !== prop_i[2]) begin
            errors++;
            $display("FAIL timeout_int cur=%h want %h", out_current_integer, prop_i[2]);
        end
`endif
        checks++;
        if (out_boolean_valid_solution !== '0 || out_integer_valid_solution !== '0) begin
            errors++;
            $display("FAIL timeout_solution_regs sol=%h/%h want 0", out_boolean_valid_solution,
                     out_integer_valid_solution);
        end
    endtask

    task automatic test_immediate_solution;
        sat_en = 1'b1; sat_target = 8'hA5;
        start_run(8'hA5, 32'hDEAD_BEEF, 7);
        // One cycle after start: in CHECK, nothing reported yet.
        checks++;
        if (out_busy !== 1'b1 || out_solution_valid !== 1'b0) begin
            errors++;
            $display("FAIL immediate_check_cycle busy=%b sv=%b want 1 0", out_busy, out_solution_valid);
        end
        @(negedge clk);
        checks++;
        if (out_solution_valid !== 1'b1 || out_timeout !== 1'b0 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL immediate_flags sv=%b to=%b busy=%b want 1 0 0", out_solution_valid, out_timeout,
                     out_busy);
        end
        checks++;
        if (out_boolean_valid_solution !== 8'hA5 || out_integer_valid_solution !== 32'hDEAD_BEEF
            || out_iteration_count !== '0) begin
            errors++;
            $display("FAIL immediate_solution sol=%h/%h cnt=%0d want a5/deadbeef 0", out_boolean_valid_solution,
                     out_integer_valid_solution, out_iteration_count);
        end
        m_sol_b = 8'hA5; m_sol_i = 32'hDEAD_BEEF;
    endtask

    task automatic test_reject_then_accept;
        bit ok, rs; int hs;
        sat_en = 1'b1; sat_target = 8'h77;
        prop_b[0] = 8'h3C; prop_i[0] = 32'h0BAD_0BAD; prop_a[0] = 1'b0;
        prop_b[1] = 8'h77; prop_i[1] = 32'h1234_5678; prop_a[1] = 1'b1;
        start_run(8'h5A, 32'h0102_0304, 5);
        drive_run(100, 1'b0, ok, hs, rs);
        checks++;
        if (hs < 1 || obs_b[0] !== 8'h5A || obs_i[0] !== 32'h0102_0304) begin
            errors++;
            $display("FAIL reject_holds cur=%h/%h want 5a/01020304", obs_b[0], obs_i[0]);
        end
        checks++;
        if (!ok || out_solution_valid !== 1'b1 || out_timeout !== 1'b0 || out_iteration_count !== 16'd2) begin
            errors++;
            $display("FAIL accept_solution_flags sv=%b to=%b cnt=%0d want 1 0 2", out_solution_valid,
                     out_timeout, out_iteration_count);
        end
        checks++;
        if (out_boolean_valid_solution !== 8'h77 || out_integer_valid_solution !== 32'h1234_5678) begin
            errors++;
            $display("FAIL accept_solution_value sol=%h/%h want 77/12345678", out_boolean_valid_solution,
                     out_integer_valid_solution);
        end
        m_sol_b = 8'h77; m_sol_i = 32'h1234_5678;
    endtask

    task automatic test_budget_zero;
        bit ok, rs; int hs;
        sat_en = 1'b0;
        start_run(8'h11, 32'hCAFE_F00D, 0);
        drive_run(20, 1'b0, ok, hs, rs);
        checks++;
        if (!ok || out_timeout !== 1'b1 || out_iteration_count !== '0) begin
            errors++;
            $display("FAIL budget0_timeout done=%b to=%b cnt=%0d want 1 1 0", ok, out_timeout,
                     out_iteration_count);
        end
        checks++;
        if (rs !== 1'b0) begin
            errors++;
            $display("FAIL budget0_no_ready ready_seen=%b want 0", rs);
        end
        checks++;
        if (out_current_boolean !== 8'h11 || out_boolean_valid_solution !== 8'h77) begin
            errors++;
            $display("FAIL budget0_hold cur=%h sol=%h want 11 77", out_current_boolean,
                     out_boolean_valid_solution);
        end
    endtask

    task automatic test_restart;
        bit ok, rs; int hs;
        logic [NB-1:0] want_final, want_hs2;
        sat_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            prop_b[k] = NB'((k + 1) * 16); prop_i[k] = IWT'($urandom); prop_a[k] = 1'b1;
        end
`ifdef MCMC_RANDOM_RESTART_EN
        want_final = 8'h01; want_hs2 = 8'h01;
`else
        want_final = 8'h40; want_hs2 = 8'h20;
`endif
        start_run(8'h01, 32'h0, 4);
        drive_run(100, 1'b0, ok, hs, rs);
        checks++;
        if (hs != 4 || obs_b[1] !== want_hs2) begin
            errors++;
            $display("FAIL restart_hs2 hs=%0d cur=%h want 4 %h", hs, obs_b[1], want_hs2);
        end
        checks++;
        if (!ok || out_current_boolean !== want_final || out_iteration_count !== 16'd4 || out_timeout !== 1'b1) begin
            errors++;
            $display("FAIL restart_final cur=%h cnt=%0d to=%b want %h 4 1", out_current_boolean,
                     out_iteration_count, out_timeout, want_final);
        end
    endtask

    // Back-to-back randomized runs, each started straight from DONE.
    task automatic test_random;
        bit ok, rs; int hs, bud, tr_bad;
        logic [NB-1:0] ib; logic [IWT-1:0] ii;
        for (int r = 0; r < 25; r++) begin
            bud = $urandom_range(0, 12);
            sat_en = ($urandom_range(0, 4) != 0);
            sat_target = NB'($urandom_range(0, 7));
            ib = NB'($urandom_range(0, 7));
            ii = IWT'($urandom);
            for (int k = 0; k < 64; k++) begin
                prop_b[k] = NB'($urandom_range(0, 7));
                prop_i[k] = IWT'($urandom);
                prop_a[k] = ($urandom_range(0, 3) != 0);
            end
            model_run(ib, ii, bud);
            start_run(ib, ii, bud);
            drive_run(400, 1'b1, ok, hs, rs);
            checks++;
            if (!ok || hs != exp_cnt || out_iteration_count !== ITW'(exp_cnt)) begin
                errors++;
                $display("FAIL rand_count run=%0d done=%b hs=%0d cnt=%0d want %0d", r, ok, hs,
                         out_iteration_count, exp_cnt);
            end
            checks++;
            if (out_solution_valid !== exp_sv || out_timeout !== exp_to) begin
                errors++;
                $display("FAIL rand_flags run=%0d sv=%b to=%b want %b %b", r, out_solution_valid,
                         out_timeout, exp_sv, exp_to);
            end
            checks++;
            if (out_current_boolean !== exp_cur_b || out_current_integer !== exp_cur_i) begin
                errors++;
                $display("FAIL rand_current run=%0d cur=%h/%h want %h/%h", r, out_current_boolean,
                         out_current_integer, exp_cur_b, exp_cur_i);
            end
            checks++;
            if (out_boolean_valid_solution !== m_sol_b || out_integer_valid_solution !== m_sol_i) begin
                errors++;
                $display("FAIL rand_solution run=%0d sol=%h/%h want %h/%h", r, out_boolean_valid_solution,
                         out_integer_valid_solution, m_sol_b, m_sol_i);
            end
            tr_bad = -1;
            for (int k = 0; k < hs && k < exp_cnt; k++)
                if (tr_bad < 0 && (obs_b[k] !== exp_b[k] || obs_i[k] !== exp_i[k])) tr_bad = k;
            checks++;
            if (tr_bad >= 0) begin
                errors++;
                $display("FAIL rand_trace run=%0d hs=%0d cur=%h/%h want %h/%h", r, tr_bad + 1,
                         obs_b[tr_bad], obs_i[tr_bad], exp_b[tr_bad], exp_i[tr_bad]);
            end
        end
    endtask

    initial begin
        m_sol_b = '0; m_sol_i = '0;
        test_reset;
        test_timeout;
        test_immediate_solution;
        test_reject_then_accept;
        test_budget_zero;
        test_restart;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcmc_assignment_manager.md
Name: mcmc_assignment_manager

Overview:
- Control and state stage directly upstream of the probabilistic search engine in the MCMC constraint solver.
- Holds the current Boolean/integer assignment and loads the initial assignment on start.
- Presents the current assignment to the search, commits accepted proposals, and samples the constraint checker's "satisfied" verdict.
- Captures the first valid solution, or flags timeout after an iteration budget.

Parameters:
NUM_BOOL, 8, number of Boolean variables
NUM_INT, 4, number of integer variables
INT_W, 8, bit width of each integer variable (two's complement, packed var0 in LSBs)
ITER_W, 16, width of iteration counter and budget

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_start  input  1  start pulse; honoured only in IDLE or DONE
in_max_iterations  input  ITER_W  iteration budget, sampled on accepted start
in_initial_boolean  input  NUM_BOOL  initial Boolean assignment, sampled on accepted start
in_initial_integer  input  NUM_INT*INT_W  initial integer assignment, sampled on accepted start
out_current_boolean  output  NUM_BOOL  current Boolean assignment (registered)
out_current_integer  output  NUM_INT*INT_W  current integer assignment (registered)
out_proposal_ready  output  1  high in ISSUE only
in_proposal_valid  input  1  search has a proposal
in_proposal_accept  input  1  Metropolis accept decision, qualifies in_proposal_valid
in_proposal_boolean  input  NUM_BOOL  proposed Boolean assignment
in_proposal_integer  input  NUM_INT*INT_W  proposed integer assignment
in_current_satisfied  input  1  constraint checker verdict on out_current_*; combinational from those outputs
out_boolean_valid_solution  output  NUM_BOOL  captured solution
out_integer_valid_solution  output  NUM_INT*INT_W  captured solution
out_solution_valid  output  1  high in DONE when a solution was found
out_timeout  output  1  high in DONE when the budget was exhausted
out_busy  output  1  high in CHECK and ISSUE
out_iteration_count  output  ITER_W  committed handshakes since start

Behaviour:
- Reset: state=IDLE; all outputs 0, including current/solution registers, count, and flags.
- States: IDLE, CHECK, ISSUE, DONE.
- IDLE/DONE + in_start:
  - current <= initial inputs; budget <= in_max_iterations; count <= 0.
  - Clear out_solution_valid and out_timeout; go to CHECK.
- CHECK (exactly 1 cycle), priority in this order:
  1. in_current_satisfied=1: solution regs <= current, out_solution_valid<=1, go to DONE.
  2. count==budget: out_timeout<=1, go to DONE.
  3. Otherwise: go to ISSUE.
- ISSUE: out_proposal_ready=1. A handshake occurs when in_proposal_valid=1 in ISSUE.
  - On handshake: count<=count+1. If in_proposal_accept=1, current <= proposal; otherwise current is unchanged. Go to CHECK.
  - Without in_proposal_valid, stay in ISSUE indefinitely.
- Latency:
  - start to first CHECK: 1 cycle.
  - handshake to updated out_current_*: 1 cycle; the verdict on the new value is sampled in that cycle.
  - Minimum 2 cycles per iteration.
- Budget 0: initial assignment checked once; if unsatisfied, timeout with count=0.
- Satisfied and budget-hit in the same CHECK: solution wins; out_timeout=0.
- Counter never wraps; it is bounded by the budget.
- in_start outside IDLE/DONE is ignored.
- in_proposal_* outside ISSUE is ignored.
- DONE: solution/timeout flags and solution regs are held until the next accepted start or rst.
- rst asserted mid-operation returns to IDLE with reset values on the next edge; an in-flight proposal is dropped.

Optional Feature:
Macro MCMC_RANDOM_RESTART_EN.
- Enabled:
  - Extra parameter RESTART_PERIOD (default 64).
  - A restart counter increments on each handshake and clears on start.
  - When it reaches RESTART_PERIOD, that handshake reloads current from the initial values latched at start, ignoring accept, and clears the restart counter.
  - out_iteration_count and the budget still count that handshake.
- Disabled: no restart counter or initial-value shadow registers; behaviour exactly as above.

Test Plan:
1. rst held 2 cycles mid-ISSUE -> state IDLE, all outputs 0, out_proposal_ready=0.
2. Start with initial bool=8'hA5, satisfied=1 in first CHECK -> out_solution_valid=1 two cycles after start, solution=8'hA5, out_iteration_count=0, out_timeout=0.
3. Budget=3, satisfied always 0, every proposal accepted with values 1,2,3 -> out_timeout=1, current bool=3, count=3, solution regs 0.
4. Budget=5, proposal 8'h3C with accept=0, then 8'h77 with accept=1 and satisfied raised -> current holds initial after the first handshake; solution=8'h77, count=2.
5. Budget=0, unsatisfied -> DONE with out_timeout=1, count=0, no proposal_ready pulse.
6. With MCMC_RANDOM_RESTART_EN and RESTART_PERIOD=2, budget=4, initial 8'h01, all proposals accepted -> current equals initial after handshakes 2 and 4; without the macro, current equals the 4th proposal.
